// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the single-cycle MIPS datapath.
//   word_t      : 32-bit machine word
//   IMM_W       : width of the I-type immediate field
//   ru_state_t  : request_unit FSM states
//   JSEL_*      : JumpSel encodings driven by the control unit (3 is reserved, treated as SEQ)
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned IMM_W = 16;

    typedef enum logic [1:0] {
        RU_FETCH,
        RU_DATA,
        RU_HALTED
    } ru_state_t;

    localparam logic [1:0] JSEL_SEQ = 2'd0;
    localparam logic [1:0] JSEL_J   = 2'd1;
    localparam logic [1:0] JSEL_JR  = 2'd2;

endpackage

// File: rtl/next_pc.sv
// Combinational next-PC selection for request_unit.
// Ports:
//   jump_sel_i   JumpSel from the control unit (0 seq/branch, 1 J/JAL, 2 JR, 3 treated as 0)
//   pc_src_i     branch taken
//   pc_plus4_i   PC + 4 of the current instruction
//   instr_i      low 26 bits of the current instruction (jump target / branch immediate)
//   rdat1_i      Rs value, JR target
//   npc_o        selected next PC (all arithmetic wraps modulo 2^32)
module next_pc
    import cpu_types_pkg::*;
(
    input  logic [1:0]  jump_sel_i,
    input  logic        pc_src_i,
    input  word_t       pc_plus4_i,
    input  logic [25:0] instr_i,
    input  word_t       rdat1_i,
    output word_t       npc_o
);

    word_t br_off;

    // Sign-extended word offset of the branch immediate.
    assign br_off = {{14{instr_i[IMM_W-1]}}, instr_i[IMM_W-1:0], 2'b00};

    always_comb begin
        npc_o = pc_plus4_i;
        case (jump_sel_i)
            JSEL_J:  npc_o = {pc_plus4_i[31:28], instr_i, 2'b00};
            JSEL_JR: npc_o = rdat1_i;
            default: begin
                if (pc_src_i) begin
                    npc_o = pc_plus4_i + br_off;
                end
            end
        endcase
    end

endmodule

// File: rtl/request_unit.sv
// request_unit: fetch/request stage feeding the control unit. Owns the PC, issues instruction
// and data requests to the cache, holds data requests until dhit and makes halt sticky.
// Optional performance counters are built when REQUEST_UNIT_PERF_EN is defined; otherwise
// retired_cnt/stall_cnt are tied to 0.
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   ihit, imemload        instruction valid / instruction word from cache
//   dhit                  data access completed
//   dREN, dWEN, halt      control-unit decode of the presented instruction
//   PCsrc, JumpSel, rdat1 next-PC controls and JR target
//   instr                 instruction presented to the control unit
//   pc, pc_plus4          current PC and PC+4
//   imemREN, imemaddr     instruction request
//   dmemREN, dmemWEN      data request
//   halt_out              sticky halt
//   pc_en                 retire pulse
//   retired_cnt, stall_cnt performance counters
module request_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  word_t       imemload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic        halt,
    input  logic        PCsrc,
    input  logic [1:0]  JumpSel,
    input  word_t       rdat1,
    output word_t       instr,
    output word_t       pc,
    output word_t       pc_plus4,
    output logic        imemREN,
    output word_t       imemaddr,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic        halt_out,
    output logic        pc_en,
    output word_t       retired_cnt,
    output word_t       stall_cnt
);

    ru_state_t state_q, state_d;
    word_t     pc_q, pc_d;
    word_t     instr_q, instr_d;
    word_t     npc;

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;
    assign imemaddr = pc_q;

    next_pc u_next_pc (
        .jump_sel_i (JumpSel),
        .pc_src_i   (PCsrc),
        .pc_plus4_i (pc_plus4),
        .instr_i    (instr[25:0]),
        .rdat1_i    (rdat1),
        .npc_o      (npc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RU_FETCH;
            pc_q    <= PC_INIT;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        instr    = instr_q;
        imemREN  = 1'b0;
        dmemREN  = 1'b0;
        dmemWEN  = 1'b0;
        halt_out = 1'b0;
        pc_en    = 1'b0;
        case (state_q)
            RU_FETCH: begin
                imemREN = 1'b1;
                instr   = imemload;
                if (ihit) begin
                    // Halt outranks any data request decoded from the same word.
                    if (halt) begin
                        state_d = RU_HALTED;
                    end else if (dREN || dWEN) begin
                        state_d = RU_DATA;
                        instr_d = imemload;
                    end else begin
                        pc_d  = npc;
                        pc_en = 1'b1;
                    end
                end
            end
            RU_DATA: begin
                // Control unit decodes instr_q here, so dREN/dWEN stay stable until dhit.
                dmemREN = dREN;
                dmemWEN = dWEN;
                if (dhit) begin
                    pc_d    = npc;
                    pc_en   = 1'b1;
                    state_d = RU_FETCH;
                end
            end
            RU_HALTED: begin
                halt_out = 1'b1;
            end
            default: begin
                state_d = RU_FETCH;
            end
        endcase
    end

`ifdef REQUEST_UNIT_PERF_EN
    word_t retired_q, retired_d;
    word_t stall_q, stall_d;
    logic  stall;

    // HALTED never stalls or retires, so both counters freeze there.
    assign stall = ((state_q == RU_FETCH) && !ihit) || ((state_q == RU_DATA) && !dhit);

    always_comb begin
        retired_d = retired_q;
        stall_d   = stall_q;
        if (pc_en && (retired_q != 32'hFFFF_FFFF)) begin
            retired_d = retired_q + 32'd1;
        end
        if (stall && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`else
    assign retired_cnt = '0;
    assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit. Expected next PCs are pushed to a scoreboard queue when
// a retiring instruction is driven and popped when the PC register updates.
module tb_request_unit;
    import cpu_types_pkg::*;

`ifdef REQUEST_UNIT_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       CLK, RST, ihit, dhit, dREN, dWEN, halt, PCsrc;
    logic [1:0] JumpSel;
    word_t      imemload, rdat1;
    word_t      instr, pc, pc_plus4, imemaddr, retired_cnt, stall_cnt;
    logic       imemREN, dmemREN, dmemWEN, halt_out, pc_en;

    int    n_checks = 0;
    int    n_errors = 0;
    word_t sb_q[$];
    int    exp_retired = 0;
    int    exp_stall = 0;

    request_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .dhit        (dhit),
        .imemload    (imemload),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .halt        (halt),
        .PCsrc       (PCsrc),
        .JumpSel     (JumpSel),
        .rdat1       (rdat1),
        .instr       (instr),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .dmemREN     (dmemREN),
        .dmemWEN     (dmemWEN),
        .halt_out    (halt_out),
        .pc_en       (pc_en),
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_retired"}, retired_cnt, PERF ? 32'(exp_retired) : 32'd0);
        check({tag, "_stall"}, stall_cnt, PERF ? 32'(exp_stall) : 32'd0);
    endtask

    task automatic pop_pc(input string tag);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_pc"}, pc, sb_q.pop_front());
        end
    endtask

    // Leaves dREN/dWEN alone so a request held mid-DATA can be seen dropping.
    task automatic do_reset();
        RST = 1'b1; ihit = 1'b0; dhit = 1'b0; halt = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        exp_retired = 0;
        exp_stall = 0;
        check("rst_pc", pc, 32'h0);
        check("rst_pc4", pc_plus4, 32'h4);
        check("rst_imemaddr", imemaddr, 32'h0);
        check("rst_imemREN", {31'd0, imemREN}, 32'd1);
        check("rst_dmemREN", {31'd0, dmemREN}, 32'd0);
        check("rst_dmemWEN", {31'd0, dmemWEN}, 32'd0);
        check("rst_halt", {31'd0, halt_out}, 32'd0);
        check("rst_pc_en", {31'd0, pc_en}, 32'd0);
        check_counters("rst");
    endtask

    task automatic fetch_retire(input string tag, input word_t word, input logic [1:0] jsel,
                                input logic br, input word_t rs, input word_t exp_next);
        ihit = 1'b1; dhit = 1'b0; halt = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        PCsrc = br; JumpSel = jsel; rdat1 = rs; imemload = word;
        @(negedge CLK);
        check({tag, "_pc_en"}, {31'd0, pc_en}, 32'd1);
        check({tag, "_instr"}, instr, word);
        sb_q.push_back(exp_next);
        exp_retired++;
        tick();
        pop_pc(tag);
    endtask

    task automatic idle(input string tag, input word_t exp_pc);
        ihit = 1'b0; dhit = 1'b0; halt = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        @(negedge CLK);
        check({tag, "_pc_en"}, {31'd0, pc_en}, 32'd0);
        check({tag, "_dmemREN"}, {31'd0, dmemREN}, 32'd0);
        exp_stall++;
        tick();
        check({tag, "_pc"}, pc, exp_pc);
    endtask

    localparam word_t ADDU = 32'h0022_1821;
    localparam word_t LW   = 32'h8C22_0004;
    localparam word_t SW   = 32'hAC22_0000;
    localparam word_t HALT = 32'hFFFF_FFFF;

    initial begin
        ihit = 0; dhit = 0; dREN = 0; dWEN = 0; halt = 0; PCsrc = 0; JumpSel = 0;
        imemload = '0; rdat1 = '0; RST = 1;
        do_reset();

        fetch_retire("addu0", ADDU, JSEL_SEQ, 1'b0, 32'h0, 32'h4);
        fetch_retire("addu1", ADDU, JSEL_SEQ, 1'b0, 32'h0, 32'h8);
        fetch_retire("addu2", ADDU, JSEL_SEQ, 1'b0, 32'h0, 32'hC);
        fetch_retire("addu3", ADDU, JSEL_SEQ, 1'b0, 32'h0, 32'h10);

        // LW at 0x10: three DATA cycles, dhit on the third.
        ihit = 1'b1; dREN = 1'b1; dWEN = 1'b0; imemload = LW; JumpSel = JSEL_SEQ; PCsrc = 0;
        @(negedge CLK);
        check("lw_fetch_pc_en", {31'd0, pc_en}, 32'd0);
        tick();
        check("lw_held_pc", pc, 32'h10);
        for (int i = 0; i < 3; i++) begin
            imemload = 32'hDEAD_BEEF; ihit = 1'b1; dhit = (i == 2); dREN = 1'b1;
            @(negedge CLK);
            check("lw_dmemREN", {31'd0, dmemREN}, 32'd1);
            check("lw_instr", instr, LW);
            check("lw_imemREN", {31'd0, imemREN}, 32'd0);
            if (dhit) begin
                check("lw_dhit_pc_en", {31'd0, pc_en}, 32'd1);
                sb_q.push_back(32'h14);
                exp_retired++;
            end else begin
                check("lw_wait_pc_en", {31'd0, pc_en}, 32'd0);
                exp_stall++;
            end
            tick();
            if (i == 2) pop_pc("lw_done");
            else check("lw_wait_pc", pc, 32'h10);
        end

        idle("stall0", 32'h14);
        idle("stall1", 32'h14);

        fetch_retire("beq_fwd", 32'h1000_0002, JSEL_SEQ, 1'b1, 32'h0, 32'h20);
        fetch_retire("beq_back", 32'h1000_FFFF, JSEL_SEQ, 1'b1, 32'h0, 32'h20);
        fetch_retire("beq_40", 32'h1000_0007, JSEL_SEQ, 1'b1, 32'h0, 32'h40);
        fetch_retire("j", 32'h0800_0100, JSEL_J, 1'b0, 32'h0, 32'h400);
        fetch_retire("jr", 32'h03E0_0008, JSEL_JR, 1'b0, 32'h88, 32'h88);
        fetch_retire("jsel3", 32'h1000_0005, 2'd3, 1'b1, 32'h0, 32'hA0);
        check_counters("mid");

        // SW into DATA, then reset while the write is outstanding.
        ihit = 1'b1; dREN = 1'b0; dWEN = 1'b1; imemload = SW; JumpSel = JSEL_SEQ; PCsrc = 0;
        tick();
        ihit = 1'b0;
        @(negedge CLK);
        check("sw_dmemWEN", {31'd0, dmemWEN}, 32'd1);
        check("sw_dmemREN", {31'd0, dmemREN}, 32'd0);
        check("sw_pc", pc, 32'hA0);
        do_reset();
        check("rst_data_dmemWEN", {31'd0, dmemWEN}, 32'd0);

        // Halt: dWEN asserted alongside must never reach the cache.
        fetch_retire("pre_halt", ADDU, JSEL_SEQ, 1'b0, 32'h0, 32'h4);
        idle("pre_halt_stall", 32'h4);
        ihit = 1'b1; halt = 1'b1; dWEN = 1'b1; imemload = HALT;
        @(negedge CLK);
        check("halt_fetch_pc_en", {31'd0, pc_en}, 32'd0);
        check("halt_fetch_dmemWEN", {31'd0, dmemWEN}, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            ihit = 1'b1; dhit = 1'b1; dWEN = 1'b1; halt = 1'b1;
            @(negedge CLK);
            check("halted_halt_out", {31'd0, halt_out}, 32'd1);
            check("halted_imemREN", {31'd0, imemREN}, 32'd0);
            check("halted_dmemWEN", {31'd0, dmemWEN}, 32'd0);
            check("halted_pc_en", {31'd0, pc_en}, 32'd0);
            tick();
            check("halted_pc", pc, 32'h4);
        end
        check_counters("halted");

        dWEN = 1'b0;
        do_reset();
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
